// File: rtl/arb_mux.sv
// Registered N-input arbitrating mux: one valid input per cycle is granted
// (round-robin or fixed priority) and captured into a single output register.
module arb_mux #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned RR_EN      = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN-1:0]            in_valid,
  input  logic [N_IN*DATA_WIDTH-1:0] in_data,
  output logic [N_IN-1:0]            in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [SEL_WIDTH-1:0]       out_sel,
  input  logic                       out_ready
);

  localparam int unsigned PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;

  logic [N_IN-1:0]       grant;
  logic                  found;
  logic [PTR_W-1:0]      gnt_idx;
  logic [PTR_W-1:0]      gnt_nxt;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  load;
  logic                  xfer;
  int unsigned           idx;
  int unsigned           nxt;

  // Scan from ptr upward with wrap (round-robin) or from 0 (fixed priority).
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_nxt  = '0;
    gnt_data = '0;
    idx      = 0;
    nxt      = 0;
    for (int unsigned off = 0; off < N_IN; off++) begin
      if (RR_EN != 0) idx = (32'(ptr_q) + off) % N_IN;
      else            idx = off;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = idx[PTR_W-1:0];
        gnt_data   = in_data[idx*DATA_WIDTH +: DATA_WIDTH];
        nxt        = (idx == N_IN - 1) ? 0 : idx + 1;
        gnt_nxt    = nxt[PTR_W-1:0];
      end
    end
  end

  assign load     = ~out_valid_q | out_ready;
  assign xfer     = load & found & ~rst;
  assign in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_sel_d   = SEL_WIDTH'(gnt_idx);
      if (RR_EN != 0) ptr_d = gnt_nxt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a round-robin and a fixed-priority instance
// share stimulus; expected values are hand-computed per step.
module tb_arb_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic            out_ready;

  logic [N-1:0]    rr_in_ready, fp_in_ready;
  logic            rr_out_valid, fp_out_valid;
  logic [DW-1:0]   rr_out_data, fp_out_data;
  logic [1:0]      rr_out_sel, fp_out_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_mux #(.N_IN(N), .DATA_WIDTH(DW), .SEL_WIDTH(2), .RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_sel(rr_out_sel), .out_ready(out_ready)
  );

  arb_mux #(.N_IN(N), .DATA_WIDTH(DW), .SEL_WIDTH(2), .RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
    .out_sel(fp_out_sel), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int unsigned ch, input logic [DW-1:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b1;

    // Reset and idle
    tick();
    tick();
    chk("rst_valid", 64'(rr_out_valid), 64'd0);
    chk("rst_data", 64'(rr_out_data), 64'd0);
    chk("rst_sel", 64'(rr_out_sel), 64'd0);
    chk("rst_ready", 64'(rr_in_ready), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 64'(rr_out_valid), 64'd0);
      chk("idle_data", 64'(rr_out_data), 64'd0);
      chk("idle_ready", 64'(rr_in_ready), 64'd0);
    end

    // Round-robin fairness
    set_ch(0, 32'hA0); set_ch(1, 32'hA1); set_ch(2, 32'hA2); set_ch(3, 32'hA3);
    in_valid = 4'hF;
    #1;
    chk("rr_ready0", 64'(rr_in_ready), 64'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_valid", 64'(rr_out_valid), 64'd1);
      chk("rr_sel", 64'(rr_out_sel), 64'(i % 4));
      chk("rr_data", 64'(rr_out_data), 64'(32'hA0 + (i % 4)));
      chk("rr_ready", 64'(rr_in_ready), 64'(4'b0001 << ((i + 1) % 4)));
    end

    // Wrap and skip: ptr is back at 0, only channels 1 and 3 valid
    in_valid = 4'b1010;
    #1;
    chk("ws_ready0", 64'(rr_in_ready), 64'b0010);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ws_sel", 64'(rr_out_sel), (i % 2 == 0) ? 64'd1 : 64'd3);
      chk("ws_data", 64'(rr_out_data), (i % 2 == 0) ? 64'hA1 : 64'hA3);
    end

    // Backpressure: ptr 0, channel 2 only
    set_ch(2, 32'hDEADBEEF);
    in_valid = 4'b0100;
    tick();
    chk("bp_sel", 64'(rr_out_sel), 64'd2);
    chk("bp_data", 64'(rr_out_data), 64'hDEADBEEF);
    in_valid = 4'b0001;
    out_ready = 1'b0;
    #1;
    chk("bp_ready_stall", 64'(rr_in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_valid", 64'(rr_out_valid), 64'd1);
      chk("bp_hold_data", 64'(rr_out_data), 64'hDEADBEEF);
      chk("bp_hold_sel", 64'(rr_out_sel), 64'd2);
      chk("bp_hold_ready", 64'(rr_in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(rr_in_ready), 64'b0001);
    tick();
    chk("bp_ch0_sel", 64'(rr_out_sel), 64'd0);
    chk("bp_ch0_data", 64'(rr_out_data), 64'hA0);

    // Drain keeps data/sel; idle does not move ptr
    in_valid = 4'b0010;
    tick();
    chk("dr_sel1", 64'(rr_out_sel), 64'd1);
    in_valid = '0;
    tick();
    chk("dr_valid", 64'(rr_out_valid), 64'd0);
    chk("dr_data_hold", 64'(rr_out_data), 64'hA1);
    chk("dr_sel_hold", 64'(rr_out_sel), 64'd1);
    tick();
    in_valid = 4'hF;
    #1;
    chk("idle_ptr", 64'(rr_in_ready), 64'b0100);

    // Fixed priority instance
    in_valid = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("fp_ready", 64'(fp_in_ready), 64'b0001);
      tick();
      chk("fp_sel", 64'(fp_out_sel), 64'd0);
      chk("fp_data", 64'(fp_out_data), 64'hA0);
    end
    out_ready = 1'b0;
    #1;
    chk("fp_stall_ready", 64'(fp_in_ready), 64'd0);

    // Reset mid-operation (RR instance holds a word, consumer stalled)
    chk("mr_pre_valid", 64'(rr_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", 64'(rr_in_ready), 64'd0);
    tick();
    chk("mr_valid", 64'(rr_out_valid), 64'd0);
    chk("mr_data", 64'(rr_out_data), 64'd0);
    chk("mr_sel", 64'(rr_out_sel), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk("mr_first_ready", 64'(rr_in_ready), 64'b0010);
    tick();
    chk("mr_first_sel", 64'(rr_out_sel), 64'd1);
    chk("mr_first_data", 64'(rr_out_data), 64'hA1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Registered N-input multiplexer with valid/ready handshaking and built-in arbitration. It replaces fixed-select muxing wherever several requesters share one consumer, for example load/store and fetch requests merging onto a single memory port, or multiple writeback sources sharing a bus. Each cycle it selects one valid input, using round-robin or fixed priority, and captures it into a single output register. The winner is held stable until the consumer accepts it.

## Interface
- N_IN, 4: number of input channels, 2..16.
- DATA_WIDTH, 32: payload width per channel.
- SEL_WIDTH, 2: width of the index output. Must be ≥ clog2(N_IN).
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  N_IN  per-channel request; bit i belongs to channel i.
- in_data  in  N_IN*DATA_WIDTH  flattened payloads; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  N_IN  per-channel accept; at most one bit high per cycle.
- out_valid  out  1  output register holds a payload.
- out_data  out  DATA_WIDTH  registered payload.
- out_sel  out  SEL_WIDTH  index of the channel that sourced out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- Single output register (out_valid, out_data, out_sel).
- load = ~out_valid | out_ready. The register may take a new word when it is empty or when it is draining this cycle.
- Arbitration (combinational):
  - RR_EN=1: scan the channels starting at ptr, upward, wrapping from N_IN-1 to 0. The first channel with in_valid high is granted.
  - RR_EN=0: the lowest index with in_valid high is granted. ptr is unused and stays 0.
- in_ready[i] = load & grant[i]. A channel transfers when in_valid[i] & in_ready[i].
- On transfer from channel g:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g == N_IN-1) ? 0 : g+1.
- Drain with no new grant (out_valid & out_ready, no input valid): out_valid <= 0. out_data and out_sel hold their old values.
- Stall (out_valid & ~out_ready): all in_ready are 0. out_data, out_sel and ptr are frozen.
- ptr changes only on a transfer. Idle cycles never move it.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. out_valid stays 1, giving full throughput.
- Input requests not granted are not consumed. Requesters must hold in_valid and in_data until they see in_ready.
- in_valid may be deasserted by a requester before it is granted. The block tolerates this; no protocol check is required.
- Unused in_valid bits do not exist: the width is exactly N_IN.

## Timing
- Reset (rst high at a clk edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 on the cycle rst is high.
- Reset mid-transfer: a payload held in the output register is discarded. No handshake completes in a cycle where rst is high.
- Latency: input handshake at edge k gives out_valid=1 with that payload after edge k, so it is visible in cycle k+1.
- Throughput: one word per cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, out_valid, out_ready and ptr. out_valid, out_data and out_sel are pure register outputs.
- While out_valid=1 and out_ready=0, out_data and out_sel must be stable.

## Test plan
- Reset and idle:
  - Stimulus: rst for 2 cycles, then all in_valid=0 and out_ready=1 for 5 cycles.
  - Response: out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout.
- Round-robin fairness (N_IN=4, RR_EN=1):
  - Stimulus: all four in_valid held high with data 0xA0..0xA3; out_ready=1.
  - Response: out_sel sequence is 0,1,2,3,0,1,… one per cycle. out_data tracks 0xA0,0xA1,…
- Wrap and skip:
  - Stimulus: only channels 3 and 1 valid, ptr=0.
  - Response: grants go 1,3,1,3. ptr wraps from 3 to 0 and channels 0 and 2 are skipped.
- Backpressure:
  - Stimulus: channel 2 is granted with 0xDEADBEEF, then out_ready=0 for 4 cycles while channel 0 is valid.
  - Response: out_valid=1, out_data=0xDEADBEEF and out_sel=2 stay stable. in_ready=0 throughout. Channel 0 is granted in the cycle out_ready returns to 1.
- Fixed priority (RR_EN=0):
  - Stimulus: channels 0 and 3 continuously valid.
  - Response: every grant goes to channel 0. in_ready[3] never asserts.
- Reset mid-operation:
  - Stimulus: assert rst while out_valid=1 and out_ready=0.
  - Response: out_valid=0 on the next cycle. After reset is released, the first grant goes to the lowest valid index at or above 0.
